// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the retirement trace recorder: FSM encoding, entry
// layout and field offsets inside a packed trace word.
package cpu_trace_pkg;

    localparam int TRACE_W   = 102;
    localparam int PC_LSB    = 70;
    localparam int INSTR_LSB = 38;
    localparam int WE_BIT    = 37;
    localparam int WADDR_LSB = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Same bit layout as the packed trace word, MSB first.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } trace_entry_t;

endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// Trace storage: single-write, single-read synchronous RAM with a registered
// read port that forwards same-cycle write data when the addresses collide.
module trace_ram
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = TRACE_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array is deliberately never reset; validity is tracked
    // by the occupancy count in the parent, so clearing it would only cost logic.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // NOTE: clocked state is always assigned with <= so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Retirement trace recorder: arms, waits for an optional PC trigger, then
// records PC / instruction / regfile write into a ring read out as a stream.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int WRAP_MODE = 0,
    parameter int FILTER_WR = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               arm,
    input  logic               trig_en,
    input  logic [31:0]        trig_pc,
    input  logic               cap_valid,
    input  logic [31:0]        cap_pc,
    input  logic [31:0]        cap_instr,
    input  logic               cap_rf_we,
    input  logic [4:0]         cap_rf_waddr,
    input  logic [31:0]        cap_rf_wdata,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [TRACE_W-1:0] rd_data,
    output logic [ADDR_W:0]    count,
    output logic               overflow,
    output logic               triggered,
    output logic [1:0]         state
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    state_t             state_q, state_n;
    logic [ADDR_W-1:0]  wr_ptr, wr_ptr_n;
    logic [ADDR_W-1:0]  rd_ptr, rd_ptr_n;
    logic [ADDR_W:0]    count_q, count_n;
    logic               overflow_q, overflow_n;
    logic               triggered_q, triggered_n;
    logic               fire, qualify, pop, full;
    logic               push_req, push, overwrite, drop, advance;
    logic               ram_we;
    logic [TRACE_W-1:0] cap_word;

    always_comb begin
        cap_word                      = '0;
        cap_word[PC_LSB +: 32]        = cap_pc;
        cap_word[INSTR_LSB +: 32]     = cap_instr;
        cap_word[WE_BIT]              = cap_rf_we;
        cap_word[WADDR_LSB +: 5]      = cap_rf_waddr;
        cap_word[31:0]                = cap_rf_wdata;
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    always_comb begin
        state_n     = state_q;
        wr_ptr_n    = wr_ptr;
        rd_ptr_n    = rd_ptr;
        count_n     = count_q;
        overflow_n  = overflow_q;
        triggered_n = triggered_q;

        full      = (count_q == FULL_COUNT);
        pop       = rd_valid && rd_ready;
        qualify   = cap_valid && ((FILTER_WR == 0) || cap_rf_we);
        fire      = (state_q == ST_ARMED) && (!trig_en || (cap_valid && (cap_pc == trig_pc)));
        // The trigger cycle records the triggering instruction itself.
        push_req  = ((state_q == ST_CAPTURE) || fire) && qualify;
        push      = push_req && (!full || pop || (WRAP_MODE != 0));
        overwrite = push && full && !pop;
        drop      = qualify && full && !pop
                    && ((push_req && (WRAP_MODE == 0)) || (state_q == ST_DONE));
        advance   = pop || overwrite;

        if (arm) begin
            state_n     = ST_ARMED;
            wr_ptr_n    = '0;
            rd_ptr_n    = '0;
            count_n     = '0;
            overflow_n  = 1'b0;
            triggered_n = 1'b0;
        end else begin
            wr_ptr_n    = wr_ptr + ADDR_W'(push);
            rd_ptr_n    = rd_ptr + ADDR_W'(advance);
            count_n     = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(advance);
            overflow_n  = overflow_q | overwrite | drop;
            triggered_n = triggered_q | fire;
            case (state_q)
                ST_ARMED:   if (fire) state_n = ST_CAPTURE;
                ST_CAPTURE: if ((WRAP_MODE == 0) && (count_n == FULL_COUNT)) state_n = ST_DONE;
                default:    state_n = state_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            count_q     <= count_n;
            overflow_q  <= overflow_n;
            triggered_q <= triggered_n;
        end
    end

    // Reading at the next head pointer keeps rd_data on the oldest entry with
    // one cycle of latency; the RAM forwards a write landing on that slot.
    assign ram_we = push && !arm && !reset;

    trace_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (TRACE_W)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (cap_word),
        .raddr (rd_ptr_n),
        .rdata (rd_data)
    );

    assign rd_valid  = (count_q != '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign triggered = triggered_q;
    assign state     = state_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: stop, wrap and write-filter instances share one
// stimulus stream and are compared against a queue-based model of the recorder.
module tb_cpu_trace_buffer;
    import cpu_trace_pkg::*;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    logic        clock = 1'b0;
    logic        reset, arm, trig_en, cap_valid, cap_rf_we, rd_ready;
    logic [31:0] trig_pc, cap_pc, cap_instr, cap_rf_wdata;
    logic [4:0]  cap_rf_waddr;

    logic               rd_valid_o  [3];
    logic [TRACE_W-1:0] rd_data_o   [3];
    logic [4:0]         count_o     [3];
    logic               overflow_o  [3];
    logic               triggered_o [3];
    logic [1:0]         state_o     [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    // Instance 0: stop mode, 1: wrap mode, 2: stop mode with write filter.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        cpu_trace_buffer #(
            .DEPTH(DEPTH), .ADDR_W(4),
            .WRAP_MODE((g == 1) ? 1 : 0), .FILTER_WR((g == 2) ? 1 : 0)
        ) dut (
            .clock(clock), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
            .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
            .cap_rf_we(cap_rf_we), .cap_rf_waddr(cap_rf_waddr), .cap_rf_wdata(cap_rf_wdata),
            .rd_valid(rd_valid_o[g]), .rd_ready(rd_ready), .rd_data(rd_data_o[g]),
            .count(count_o[g]), .overflow(overflow_o[g]), .triggered(triggered_o[g]),
            .state(state_o[g])
        );
    end

    // ---------------- reference model ----------------
    trace_entry_t q0[$], q1[$], q2[$];
    int mst   [3];
    bit movf  [3];
    bit mtrig [3];

    function automatic int msize(int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic trace_entry_t mhead(int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic mpop(int k);
        case (k)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic mpush(int k, trace_entry_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic mclear(int k);
        case (k)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic model_edge(int k);
        bit wrap, filt, fire, qual;
        trace_entry_t e;
        wrap = (k == 1);
        filt = (k == 2);
        e = '{cap_pc, cap_instr, cap_rf_we, cap_rf_waddr, cap_rf_wdata};
        if (reset || arm) begin
            mclear(k);
            mst[k]   = reset ? 0 : 1;
            movf[k]  = 0;
            mtrig[k] = 0;
        end else begin
            fire = (mst[k] == 1) && (!trig_en || (cap_valid && cap_pc == trig_pc));
            qual = cap_valid && (!filt || cap_rf_we);
            if (rd_ready && msize(k) > 0) mpop(k);
            if (fire) begin
                mtrig[k] = 1;
                mst[k]   = 2;
            end
            if (mst[k] == 2 && qual) begin
                if (msize(k) < DEPTH) begin
                    mpush(k, e);
                end else if (wrap) begin
                    mpop(k);
                    mpush(k, e);
                    movf[k] = 1;
                end else begin
                    movf[k] = 1;
                end
            end else if (mst[k] == 3 && qual && msize(k) == DEPTH) begin
                movf[k] = 1;
            end
            if (mst[k] == 2 && !wrap && msize(k) == DEPTH) mst[k] = 3;
        end
    endtask

    task automatic step();
        @(posedge clock);
        for (int k = 0; k < 3; k++) model_edge(k);
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_arm(bit te, logic [31:0] tp);
        arm = 1'b1; trig_en = te; trig_pc = tp;
        step();
        arm = 1'b0;
    endtask

    task automatic retire(logic [31:0] pc, bit we, logic [4:0] wa, logic [31:0] wd);
        cap_valid = 1'b1; cap_pc = pc; cap_instr = $urandom;
        cap_rf_we = we; cap_rf_waddr = wa; cap_rf_wdata = wd;
        step();
        cap_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            n_checks += 6;
            if (state_o[k] !== 2'd0) begin n_fail++; $display("FAIL reset_state[%0d]: got %0d want 0", k, state_o[k]); end
            if (count_o[k] !== 5'd0) begin n_fail++; $display("FAIL reset_count[%0d]: got %0d want 0", k, count_o[k]); end
            if (rd_valid_o[k] !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid[%0d]: got %b want 0", k, rd_valid_o[k]); end
            if (overflow_o[k] !== 1'b0) begin n_fail++; $display("FAIL reset_overflow[%0d]: got %b want 0", k, overflow_o[k]); end
            if (triggered_o[k] !== 1'b0) begin n_fail++; $display("FAIL reset_triggered[%0d]: got %b want 0", k, triggered_o[k]); end
            if (rd_data_o[k] !== '0) begin n_fail++; $display("FAIL reset_rd_data[%0d]: got %h want 0", k, rd_data_o[k]); end
        end
        reset = 1'b0;
    endtask

    task automatic test_immediate();
        do_arm(1'b0, 32'h0);
        step();
        n_checks += 2;
        if (state_o[0] !== 2'd2) begin n_fail++; $display("FAIL imm_state: got %0d want 2", state_o[0]); end
        if (triggered_o[0] !== 1'b1) begin n_fail++; $display("FAIL imm_triggered: got %b want 1", triggered_o[0]); end
        for (int i = 0; i < 5; i++) retire(BASE + 32'(4*i), 1'b1, 5'($urandom), $urandom);
        n_checks += 3;
        if (count_o[0] !== 5'd5) begin n_fail++; $display("FAIL imm_count: got %0d want 5", count_o[0]); end
        if (overflow_o[0] !== 1'b0) begin n_fail++; $display("FAIL imm_overflow: got %b want 0", overflow_o[0]); end
        if (rd_valid_o[0] !== 1'b1) begin n_fail++; $display("FAIL imm_rd_valid: got %b want 1", rd_valid_o[0]); end
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks += 2;
            if (rd_data_o[0][PC_LSB +: 32] !== BASE + 32'(4*i)) begin
                n_fail++; $display("FAIL imm_pop_pc[%0d]: got %h want %h", i, rd_data_o[0][PC_LSB +: 32], BASE + 32'(4*i));
            end
            if (rd_data_o[0] !== mhead(0)) begin
                n_fail++; $display("FAIL imm_pop_entry[%0d]: got %h want %h", i, rd_data_o[0], mhead(0));
            end
            step();
        end
        rd_ready = 1'b0;
        n_checks += 2;
        if (count_o[0] !== 5'd0) begin n_fail++; $display("FAIL imm_drained_count: got %0d want 0", count_o[0]); end
        if (rd_valid_o[0] !== 1'b0) begin n_fail++; $display("FAIL imm_drained_valid: got %b want 0", rd_valid_o[0]); end
    endtask

    task automatic test_trigger();
        do_arm(1'b1, 32'h0040_000c);
        for (int i = 0; i < 6; i++) begin
            retire(BASE + 32'(4*i), 1'b1, 5'($urandom), $urandom);
            n_checks++;
            if (triggered_o[0] !== (i >= 3)) begin
                n_fail++; $display("FAIL trig_flag[pc=%h]: got %b want %b", BASE + 32'(4*i), triggered_o[0], (i >= 3));
            end
        end
        n_checks += 3;
        if (count_o[0] !== 5'd3) begin n_fail++; $display("FAIL trig_count: got %0d want 3", count_o[0]); end
        if (state_o[0] !== 2'd2) begin n_fail++; $display("FAIL trig_state: got %0d want 2", state_o[0]); end
        if (rd_data_o[0][PC_LSB +: 32] !== 32'h0040_000c) begin
            n_fail++; $display("FAIL trig_first_pc: got %h want 0040000c", rd_data_o[0][PC_LSB +: 32]);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rd_data_o[0] !== mhead(0)) begin n_fail++; $display("FAIL trig_entry[%0d]: got %h want %h", i, rd_data_o[0], mhead(0)); end
            step();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_full_stop_wrap();
        do_arm(1'b0, 32'h0);
        step();
        for (int i = 0; i < 20; i++) retire(BASE + 32'(4*i), 1'b1, 5'($urandom), $urandom);
        n_checks += 7;
        if (count_o[0] !== 5'd16) begin n_fail++; $display("FAIL stop_count: got %0d want 16", count_o[0]); end
        if (state_o[0] !== 2'd3) begin n_fail++; $display("FAIL stop_state: got %0d want 3", state_o[0]); end
        if (overflow_o[0] !== 1'b1) begin n_fail++; $display("FAIL stop_overflow: got %b want 1", overflow_o[0]); end
        if (count_o[1] !== 5'd16) begin n_fail++; $display("FAIL wrap_count: got %0d want 16", count_o[1]); end
        if (state_o[1] !== 2'd2) begin n_fail++; $display("FAIL wrap_state: got %0d want 2", state_o[1]); end
        if (overflow_o[1] !== 1'b1) begin n_fail++; $display("FAIL wrap_overflow: got %b want 1", overflow_o[1]); end
        if (rd_data_o[1][PC_LSB +: 32] !== BASE + 32'd16) begin
            n_fail++; $display("FAIL wrap_first_pc: got %h want %h", rd_data_o[1][PC_LSB +: 32], BASE + 32'd16);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks += 4;
            if (rd_data_o[0][PC_LSB +: 32] !== BASE + 32'(4*i)) begin
                n_fail++; $display("FAIL stop_pop_pc[%0d]: got %h want %h", i, rd_data_o[0][PC_LSB +: 32], BASE + 32'(4*i));
            end
            if (rd_data_o[1][PC_LSB +: 32] !== BASE + 32'(4*(i+4))) begin
                n_fail++; $display("FAIL wrap_pop_pc[%0d]: got %h want %h", i, rd_data_o[1][PC_LSB +: 32], BASE + 32'(4*(i+4)));
            end
            if (rd_data_o[0] !== mhead(0)) begin n_fail++; $display("FAIL stop_entry[%0d]: got %h want %h", i, rd_data_o[0], mhead(0)); end
            if (rd_data_o[1] !== mhead(1)) begin n_fail++; $display("FAIL wrap_entry[%0d]: got %h want %h", i, rd_data_o[1], mhead(1)); end
            step();
        end
        rd_ready = 1'b0;
        n_checks++;
        if (state_o[0] !== 2'd3) begin n_fail++; $display("FAIL stop_state_drained: got %0d want 3", state_o[0]); end
    endtask

    task automatic test_filter();
        logic [4:0]  wa [8];
        logic [31:0] wd [8];
        do_arm(1'b0, 32'h0);
        step();
        for (int i = 0; i < 8; i++) begin
            wa[i] = 5'($urandom);
            wd[i] = $urandom;
            retire(BASE + 32'(4*i), (i % 2) == 0, wa[i], wd[i]);
        end
        n_checks += 2;
        if (count_o[2] !== 5'd4) begin n_fail++; $display("FAIL filt_count: got %0d want 4", count_o[2]); end
        if (count_o[0] !== 5'd8) begin n_fail++; $display("FAIL nofilt_count: got %0d want 8", count_o[0]); end
        rd_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            n_checks += 4;
            if (rd_data_o[2][WE_BIT] !== 1'b1) begin n_fail++; $display("FAIL filt_we[%0d]: got %b want 1", j, rd_data_o[2][WE_BIT]); end
            if (rd_data_o[2][WADDR_LSB +: 5] !== wa[2*j]) begin
                n_fail++; $display("FAIL filt_waddr[%0d]: got %0d want %0d", j, rd_data_o[2][WADDR_LSB +: 5], wa[2*j]);
            end
            if (rd_data_o[2][31:0] !== wd[2*j]) begin
                n_fail++; $display("FAIL filt_wdata[%0d]: got %h want %h", j, rd_data_o[2][31:0], wd[2*j]);
            end
            if (rd_data_o[2] !== mhead(2)) begin n_fail++; $display("FAIL filt_entry[%0d]: got %h want %h", j, rd_data_o[2], mhead(2)); end
            step();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_arm(1'b0, 32'h0);
        step();
        for (int i = 0; i < 16; i++) retire(BASE + 32'(4*i), 1'b1, 5'($urandom), $urandom);
        rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            retire(BASE + 32'h100 + 32'(4*i), 1'b1, 5'($urandom), $urandom);
            n_checks += 3;
            if (count_o[1] !== 5'd16) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want 16", i, count_o[1]); end
            if (overflow_o[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow[%0d]: got %b want 0", i, overflow_o[1]); end
            if (rd_data_o[1] !== mhead(1)) begin n_fail++; $display("FAIL b2b_entry[%0d]: got %h want %h", i, rd_data_o[1], mhead(1)); end
        end
        rd_ready = 1'b0;
        for (int c = 0; c < 400; c++) begin
            reset        = ($urandom_range(0, 149) == 0);
            arm          = ($urandom_range(0, 39) == 0);
            if (arm) begin
                trig_en = $urandom_range(0, 1);
                trig_pc = BASE + 32'(4 * $urandom_range(0, 7));
            end
            cap_valid    = $urandom_range(0, 2) != 0;
            cap_pc       = BASE + 32'(4 * $urandom_range(0, 7));
            cap_instr    = $urandom;
            cap_rf_we    = $urandom_range(0, 1);
            cap_rf_waddr = 5'($urandom);
            cap_rf_wdata = $urandom;
            rd_ready     = ($urandom_range(0, 3) == 0);
            step();
            for (int k = 0; k < 3; k++) begin
                n_checks += 5;
                if (count_o[k] !== 5'(msize(k))) begin n_fail++; $display("FAIL rnd_count[%0d] cyc %0d: got %0d want %0d", k, c, count_o[k], msize(k)); end
                if (rd_valid_o[k] !== (msize(k) > 0)) begin n_fail++; $display("FAIL rnd_valid[%0d] cyc %0d: got %b want %b", k, c, rd_valid_o[k], msize(k) > 0); end
                if (overflow_o[k] !== movf[k]) begin n_fail++; $display("FAIL rnd_overflow[%0d] cyc %0d: got %b want %b", k, c, overflow_o[k], movf[k]); end
                if (triggered_o[k] !== mtrig[k]) begin n_fail++; $display("FAIL rnd_triggered[%0d] cyc %0d: got %b want %b", k, c, triggered_o[k], mtrig[k]); end
                if (state_o[k] !== 2'(mst[k])) begin n_fail++; $display("FAIL rnd_state[%0d] cyc %0d: got %0d want %0d", k, c, state_o[k], mst[k]); end
                if (msize(k) > 0) begin
                    n_checks++;
                    if (rd_data_o[k] !== mhead(k)) begin n_fail++; $display("FAIL rnd_entry[%0d] cyc %0d: got %h want %h", k, c, rd_data_o[k], mhead(k)); end
                end
            end
        end
        reset = 1'b0; arm = 1'b0; cap_valid = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_arm(1'b0, 32'h0);
        step();
        for (int i = 0; i < 7; i++) retire(BASE + 32'(4*i), 1'b1, 5'($urandom), $urandom);
        n_checks++;
        if (count_o[0] !== 5'd7) begin n_fail++; $display("FAIL mid_count_before: got %0d want 7", count_o[0]); end
        reset = 1'b1;
        retire(BASE + 32'h40, 1'b1, 5'd1, 32'h1);
        reset = 1'b0;
        n_checks += 3;
        if (state_o[0] !== 2'd0) begin n_fail++; $display("FAIL mid_state: got %0d want 0", state_o[0]); end
        if (count_o[0] !== 5'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", count_o[0]); end
        if (rd_valid_o[0] !== 1'b0) begin n_fail++; $display("FAIL mid_rd_valid: got %b want 0", rd_valid_o[0]); end
        do_arm(1'b0, 32'h0);
        step();
        for (int i = 0; i < 3; i++) retire(BASE + 32'(4*i), 1'b1, 5'($urandom), $urandom);
        arm = 1'b1;
        retire(BASE + 32'h80, 1'b1, 5'd2, 32'h2);
        arm = 1'b0;
        n_checks += 4;
        if (count_o[0] !== 5'd0) begin n_fail++; $display("FAIL arm_push_count: got %0d want 0", count_o[0]); end
        if (state_o[0] !== 2'd1) begin n_fail++; $display("FAIL arm_push_state: got %0d want 1", state_o[0]); end
        if (rd_valid_o[0] !== 1'b0) begin n_fail++; $display("FAIL arm_push_valid: got %b want 0", rd_valid_o[0]); end
        if (triggered_o[0] !== 1'b0) begin n_fail++; $display("FAIL arm_push_triggered: got %b want 0", triggered_o[0]); end
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; trig_en = 1'b0; trig_pc = '0;
        cap_valid = 1'b0; cap_pc = '0; cap_instr = '0; cap_rf_we = 1'b0;
        cap_rf_waddr = '0; cap_rf_wdata = '0; rd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin mst[k] = 0; movf[k] = 0; mtrig[k] = 0; end
        test_reset();
        test_immediate();
        test_trigger();
        test_full_stop_wrap();
        test_filter();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Synthesizable retirement-trace recorder for the single-cycle CPU. It captures per-instruction architectural events into a parametrised on-chip ring buffer: PC, instruction word and register-file write. The buffer is read out through a valid/ready stream for on-board debug or bench comparison. It adds a PC-match trigger, a write-only filter and wrap/stop buffering modes. Sits beside the CPU in sccomp_dataflow and taps the PC, instruction-memory output and regfile write port.

Parameters:
DEPTH, 16, number of trace entries; power of two, at least 2
ADDR_W, 4, log2(DEPTH)
WRAP_MODE, 0, 0 = stop capturing when full; 1 = overwrite oldest entry when full
FILTER_WR, 0, 0 = record every retired instruction; 1 = record only retirements with cap_rf_we=1

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state
arm  in  1  one-cycle pulse; flushes the buffer and enters ARMED
trig_en  in  1  1 = wait for PC match before capturing; 0 = capture immediately after arm
trig_pc  in  32  trigger PC value
cap_valid  in  1  an instruction retires this cycle
cap_pc  in  32  PC of the retiring instruction
cap_instr  in  32  instruction word
cap_rf_we  in  1  regfile write enable
cap_rf_waddr  in  5  regfile write address
cap_rf_wdata  in  32  regfile write data
rd_valid  out  1  buffer not empty
rd_ready  in  1  consumer accepts the entry
rd_data  out  102  oldest entry {pc[101:70], instr[69:38], we[37], waddr[36:32], wdata[31:0]}
count  out  ADDR_W+1  entries held
overflow  out  1  at least one entry was lost (stop mode) or overwritten (wrap mode)
triggered  out  1  trigger has fired since the last arm
state  out  2  current FSM state encoding

Behaviour:
- Reset values: state=IDLE, count=0, rd_valid=0, overflow=0, triggered=0, rd_data=0. Read and write pointers are 0.
- FSM states: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
  - IDLE -> ARMED on arm.
  - ARMED -> CAPTURE on the first cycle with cap_valid=1 and cap_pc==trig_pc, or in the cycle after arm when trig_en=0.
  - CAPTURE -> DONE when the buffer becomes full and WRAP_MODE=0. WRAP_MODE=1 never leaves CAPTURE.
  - arm from any state flushes: pointers=0, count=0, overflow=0, triggered=0, next state ARMED. arm takes priority over same-cycle push and pop.
- The triggering instruction itself is recorded, so the first entry has pc==trig_pc. triggered is set in the same edge as the ARMED->CAPTURE transition.
- Push condition: state==CAPTURE (or the trigger cycle) and cap_valid and (FILTER_WR==0 or cap_rf_we). An entry pushed on edge N is visible on rd_data after edge N when the buffer was empty, so latency is 1 cycle.
- rd_data is registered from the memory at the read pointer and shows the oldest entry whenever rd_valid=1. A pop happens when rd_valid and rd_ready are both 1.
- Simultaneous push and pop: count unchanged and both pointers advance. This is legal when full: in stop mode the push succeeds because a slot is freed, and no overflow is flagged.
- Full with push and no pop:
  - WRAP_MODE=0: the entry is dropped, overflow=1 and state=DONE.
  - WRAP_MODE=1: the oldest entry is overwritten, both pointers advance, count stays DEPTH and overflow=1.
- Empty with pop: not possible, because rd_valid=0.
- Pointers wrap modulo DEPTH. count has range 0..DEPTH.
- DONE: no pushes; reads continue until empty; state stays DONE until arm.
- Reset mid-capture discards all contents. Memory contents need not be cleared, but rd_valid=0.

Decomposition:
- Shared package cpu_trace_pkg holds:
  - ST_IDLE/ST_ARMED/ST_CAPTURE/ST_DONE localparams;
  - TRACE_W=102;
  - entry field offsets PC_LSB=70, INSTR_LSB=38, WE_BIT=37, WADDR_LSB=32.
- One natural sub-module: trace_ram, a DEPTH x TRACE_W single-write, single-read synchronous RAM.
- FSM and pointer logic stay in the top level.

Test Plan:
- DEPTH=16, trig_en=0, 5 retirements with pc=0x00400000+4k -> count=5; popped pc sequence 0x00400000..0x00400010; overflow=0.
- trig_en=1, trig_pc=0x0040000c, retire pc 0x00400000..0x00400014 -> triggered goes to 1 at the 0x0040000c edge; 3 entries, first pc=0x0040000c.
- WRAP_MODE=0, 20 pushes with no reads -> count=16, state=DONE, overflow=1; the entries read out are the first 16.
- WRAP_MODE=1, 20 pushes with no reads -> count=16, state=CAPTURE, overflow=1; the first read has pc of push #5 (0-based 4).
- FILTER_WR=1: alternating we=1/0 over 8 retirements -> 4 entries, all with we=1 and waddr/wdata matching the stimulus. Full buffer with simultaneous push and pop -> count stays 16, overflow=0.
- Reset asserted mid-capture with count=7 -> next cycle: state=IDLE, count=0, rd_valid=0; arm during a push -> count=0.
